if_fetch_buffer: RTL
====================

Name: if_fetch_buffer

Overview:
- Fetch-side producer of the IF->ID instruction packet consumed by the decoder: issues sequential I-cache requests, buffers returned instructions in a FIFO, and presents {valid, inst, PC, NPC} to decode under a valid/ready handshake.
- Handles redirect/squash from branch resolution and stops fetching once a WFI (halt) has been buffered.

Parameters:
- DEPTH, 8, number of instruction-buffer entries (power of 2, ≥2)
- RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- redirect_en  in  1  squash buffer and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0)
- icache_req_valid  out  1  fetch request valid
- icache_req_addr  out  32  fetch address (word aligned)
- icache_req_ready  in  1  I-cache accepts request this cycle
- icache_rsp_valid  in  1  instruction return for the single outstanding request
- icache_rsp_inst  in  32  returned instruction word
- dec_pkt_valid  out  1  head packet valid to decoder
- dec_pkt_inst  out  32  head instruction
- dec_pkt_pc  out  32  head PC
- dec_pkt_npc  out  32  head PC+4
- dec_ready  in  1  decoder consumes head this cycle
- buf_count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, immediate): queue empty (head=tail=count=0), entries cleared, fetch_pc=RESET_PC, state=RUN. All outputs 0 except icache_req_addr=RESET_PC.
- FSM states:
  - RUN: may issue a request.
  - WAIT: one request outstanding.
  - DRAIN: outstanding response belongs to squashed path.
  - HALTED: WFI buffered, no fetch.
- Request: icache_req_valid = (state==RUN) && (count<DEPTH) && !redirect_en; icache_req_addr = fetch_pc. At most one request outstanding; the slot is reserved by the count<DEPTH check, so an enqueue into a full buffer is impossible.
- RUN: req_valid && req_ready -> WAIT. icache_rsp_valid ignored in RUN, DRAIN-exit, and HALTED.
- WAIT + rsp_valid (no redirect):
  - Enqueue {inst, pc=fetch_pc, npc=fetch_pc+4}; fetch_pc += 4 (mod 2^32 wrap).
  - If inst==32'h1050_0073 (WFI) -> HALTED, else -> RUN.
  - Response never arrives in the same cycle the request is accepted.
- Decode side:
  - dec_pkt_valid = (count>0) && !redirect_en; dec_pkt_* driven combinationally from the head entry.
  - Dequeue when dec_pkt_valid && dec_ready.
  - No bypass: an enqueued entry is visible the following cycle.
  - Simultaneous enqueue and dequeue: count unchanged, pointers both advance with wrap at DEPTH.
- Redirect (priority over everything):
  - Flush queue (count=0, pointers=0); fetch_pc = {redirect_pc[31:2],2'b00}.
  - Next state:
    - WAIT without rsp_valid -> DRAIN.
    - WAIT with rsp_valid -> response dropped -> RUN.
    - DRAIN -> stays DRAIN.
    - RUN/HALTED -> RUN.
  - No request is issued in the redirect cycle.
- DRAIN: next rsp_valid discarded (no enqueue, fetch_pc unchanged) -> RUN.
- HALTED: buffered entries (including WFI) continue to drain to decode; only redirect or reset leaves HALTED.
- buf_count reflects registered occupancy (post-flush value appears the cycle after redirect).

Test Plan:
- Sequential fetch: reset, req_ready=1, responses 1 cycle after accept with insts 0x00100093, 0x00200113, 0x00308193; dec_ready=1 -> packets in order with pc 0x0/0x4/0x8, npc 0x4/0x8/0xC; req addrs 0x0, 0x4, 0x8, 0xC.
- Full/backpressure: dec_ready=0, 8 responses -> buf_count=8, icache_req_valid=0 with addr 0x20. One cycle dec_ready=1 -> head pc 0x0 consumed, count=7, req reissued at 0x20 the next cycle.
- Redirect in WAIT: request at 0x10 accepted, then redirect_en with redirect_pc=0x103 -> dec_pkt_valid=0 that cycle, count=0 next. Late response discarded, following req addr=0x100, first packet pc=0x100.
- Redirect coincident with response: rsp_valid and redirect_en (pc 0x200) same cycle -> no enqueue, state RUN, next cycle req_valid=1 addr=0x200.
- Halt: WFI 0x10500073 returned for pc 0x8 -> no further requests. Packets pc 0x0, 0x4, 0x8 (WFI, npc 0xC) delivered. Redirect to 0x40 -> fetch resumes at 0x40.
- Async reset mid-WAIT: assert reset between clock edges -> dec_pkt_valid=0, buf_count=0 immediately. After release, req addr=RESET_PC and the stale response is ignored (state RUN).

Source files
------------

// File: rtl/if_fetch_buffer.sv
// Instruction fetch buffer: issues sequential I-cache requests, queues returned words and
// presents {inst, pc, npc} packets to decode, with redirect/squash and WFI halt handling.
module if_fetch_buffer #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     redirect_en,
  input  logic [31:0]              redirect_pc,
  output logic                     icache_req_valid,
  output logic [31:0]              icache_req_addr,
  input  logic                     icache_req_ready,
  input  logic                     icache_rsp_valid,
  input  logic [31:0]              icache_rsp_inst,
  output logic                     dec_pkt_valid,
  output logic [31:0]              dec_pkt_inst,
  output logic [31:0]              dec_pkt_pc,
  output logic [31:0]              dec_pkt_npc,
  input  logic                     dec_ready,
  output logic [$clog2(DEPTH):0]   buf_count
);

  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(DEPTH);
  localparam logic [31:0] WfiInst  = 32'h1050_0073;

  typedef enum logic [1:0] {StRun, StWait, StDrain, StHalted} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PtrW:0]     count_q, count_d;
  logic [31:0]       inst_q [DEPTH];
  logic [31:0]       inst_d [DEPTH];
  logic [31:0]       pc_q   [DEPTH];
  logic [31:0]       pc_d   [DEPTH];
  logic [31:0]       npc_q  [DEPTH];
  logic [31:0]       npc_d  [DEPTH];
  logic              enq, deq;

  // Request valid is held low during reset so every output reads 0 while reset is asserted.
  assign icache_req_valid = (state_q == StRun) && (count_q < DepthCnt) && !redirect_en && !reset;
  assign icache_req_addr  = fetch_pc_q;
  assign dec_pkt_valid    = (count_q != '0) && !redirect_en;
  assign dec_pkt_inst     = inst_q[head_q];
  assign dec_pkt_pc       = pc_q[head_q];
  assign dec_pkt_npc      = npc_q[head_q];
  assign buf_count        = count_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inst_d     = inst_q;
    pc_d       = pc_q;
    npc_d      = npc_q;
    enq        = 1'b0;
    deq        = dec_pkt_valid && dec_ready;

    if (redirect_en) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      // A request still in flight must have its response swallowed later.
      unique case (state_q)
        StWait:   state_d = icache_rsp_valid ? StRun : StDrain;
        StDrain:  state_d = StDrain;
        StRun:    state_d = StRun;
        StHalted: state_d = StRun;
      endcase
    end else begin
      unique case (state_q)
        StRun: begin
          if (icache_req_valid && icache_req_ready) state_d = StWait;
        end
        StWait: begin
          if (icache_rsp_valid) begin
            enq        = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = (icache_rsp_inst == WfiInst) ? StHalted : StRun;
          end
        end
        StDrain: begin
          if (icache_rsp_valid) state_d = StRun;
        end
        StHalted: ;
      endcase

      if (enq) begin
        inst_d[tail_q] = icache_rsp_inst;
        pc_d[tail_q]   = fetch_pc_q;
        npc_d[tail_q]  = fetch_pc_q + 32'd4;
        tail_d         = tail_q + 1'b1;
      end
      if (deq) head_d = head_q + 1'b1;
      count_d = count_q + (PtrW + 1)'(enq) - (PtrW + 1)'(deq);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StRun;
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inst_q     <= '{default: '0};
      pc_q       <= '{default: '0};
      npc_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      npc_q      <= npc_d;
    end
  end

endmodule
